switch_debouncer_2ch: RTL

Two-channel input conditioner that sits directly upstream of the lab's 2-input gate blocks such as and_gate. It takes raw, bouncing, asynchronous board switch/push-button signals and passes each through a two-flop synchroniser and a consecutive-sample debounce counter. It drives clean level outputs a and b, which connect straight to the gate's a/b inputs. It also emits one-cycle rise/fall pulses and a settled flag for downstream logging/counting logic.

---
 rtl/switch_debouncer_2ch_pkg.sv | 14 +
 rtl/switch_debouncer_2ch_debounce_ch.sv | 83 ++++++++
 rtl/switch_debouncer_2ch.sv | 53 +++++
 3 files changed

// File: rtl/switch_debouncer_2ch_pkg.sv
// Shared definitions for the two-channel switch debouncer: channel state encoding
// and default / reduced-for-simulation debounce lengths.
package switch_debouncer_2ch_pkg;

    typedef enum logic {
        StStable = 1'b0,
        StCheck  = 1'b1
    } deb_state_e;

    localparam int unsigned DefaultDebounceCycles = 16;
    localparam int unsigned SimDebounceCycles     = 4;
    localparam int unsigned DefaultCntWidth       = 5;

endpackage

// File: rtl/switch_debouncer_2ch_debounce_ch.sv
// One debounce channel: two-flop synchroniser feeding a consecutive-sample counter
// that only lets the output follow a level held for DEBOUNCE_CYCLES synchronised cycles.
module debounce_ch
    import switch_debouncer_2ch_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DefaultDebounceCycles,
    parameter int unsigned CNT_WIDTH       = DefaultCntWidth
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_in,
    output logic level,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam logic [CNT_WIDTH-1:0] CntLast = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CntOne  = CNT_WIDTH'(1);

    logic                 r_sync1;
    logic                 r_sync2;
    logic                 r_level;
    logic                 r_rise;
    logic                 r_fall;
    logic [CNT_WIDTH-1:0] r_cnt;
    deb_state_e           r_state;
    logic                 w_mismatch;

    assign w_mismatch = r_sync2 ^ r_level;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_cnt   <= '0;
            r_state <= StStable;
        end else begin
            r_sync1 <= raw_in;
            r_sync2 <= r_sync1;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            case (r_state)
                StStable: begin
                    if (w_mismatch) begin
                        r_state <= StCheck;
                        r_cnt   <= CntOne;
                    end else begin
                        r_cnt <= '0;
                    end
                end
                StCheck: begin
                    // A bounce back to the current level throws away all progress.
                    if (!w_mismatch) begin
                        r_cnt   <= '0;
                        r_state <= StStable;
                    end else if (r_cnt == CntLast) begin
                        r_level <= r_sync2;
                        r_rise  <= r_sync2;
                        r_fall  <= ~r_sync2;
                        r_cnt   <= '0;
                        r_state <= StStable;
                    end else begin
                        r_cnt <= r_cnt + CntOne;
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= StStable;
                end
            endcase
        end
    end

    assign level = r_level;
    assign rise  = r_rise;
    assign fall  = r_fall;
    assign busy  = (r_state == StCheck);

endmodule

// File: rtl/switch_debouncer_2ch.sv
// Two independent debounce channels conditioning raw board switches into clean
// gate inputs a/b, with edge pulses and a combined settled flag.
module switch_debouncer_2ch
    import switch_debouncer_2ch_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DefaultDebounceCycles,
    parameter int unsigned CNT_WIDTH       = DefaultCntWidth
) (
    input  logic clk,
    input  logic rst,
    input  logic sw_a_in,
    input  logic sw_b_in,
    output logic a,
    output logic b,
    output logic a_rise,
    output logic a_fall,
    output logic b_rise,
    output logic b_fall,
    output logic stable
);

    logic w_busy_a;
    logic w_busy_b;

    debounce_ch #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_WIDTH      (CNT_WIDTH)
    ) u_ch_a (
        .clk   (clk),
        .rst   (rst),
        .raw_in(sw_a_in),
        .level (a),
        .rise  (a_rise),
        .fall  (a_fall),
        .busy  (w_busy_a)
    );

    debounce_ch #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_WIDTH      (CNT_WIDTH)
    ) u_ch_b (
        .clk   (clk),
        .rst   (rst),
        .raw_in(sw_b_in),
        .level (b),
        .rise  (b_rise),
        .fall  (b_fall),
        .busy  (w_busy_b)
    );

    assign stable = ~w_busy_a & ~w_busy_b;

endmodule
